// File: rtl/nv_nvdla_pdp_group_tracker.sv
// nv_nvdla_pdp_group_tracker: PDP register-group ownership tracker (IDLE/PENDING/RUNNING per group).
// Optional busy-cycle counters per group when NVDLA_PDP_GROUP_PERF_EN is defined.
module nv_nvdla_pdp_group_tracker #(
   parameter int PERF_CNT_W = 32
) (
   input  logic       nvdla_core_clk,
   input  logic       nvdla_core_rst,
   input  logic       producer,
   input  logic       op_en_wr,
   input  logic       op_done,
   output logic       consumer,
   output logic [1:0] status_0,
   output logic [1:0] status_1,
   output logic       op_en_0,
   output logic       op_en_1,
   output logic       op_start,
   output logic [1:0] done_intr,
   output logic       err_pulse
`ifdef NVDLA_PDP_GROUP_PERF_EN
   ,
   output logic [PERF_CNT_W-1:0] perf_busy_0,
   output logic [PERF_CNT_W-1:0] perf_busy_1
`endif
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUNNING = 2'd1, PENDING = 2'd2} grp_st_t;

   if (PERF_CNT_W < 1) begin : g_chk
      $error("PERF_CNT_W must be at least 1");
   end

   grp_st_t    r_st [2];
   grp_st_t    w_nxt [2];
   logic       r_consumer, r_op_start, r_err;
   logic [1:0] r_done;
   logic [1:0] w_start, w_done;
   logic       w_run_any, w_err, w_wr;

   always_comb begin
      w_run_any = (r_st[0] == RUNNING) || (r_st[1] == RUNNING);
      w_err     = op_done && !w_run_any;
      w_start   = '0;
      w_done    = '0;
      w_wr      = 1'b0;
      for (int i = 0; i < 2; i++) begin
         w_nxt[i] = r_st[i];
         w_wr     = op_en_wr && (producer == 1'(i));
         if (r_st[i] == IDLE) begin
            w_nxt[i] = w_wr ? PENDING : IDLE;
         end else if (r_st[i] == PENDING) begin
            w_err = w_err | w_wr;
            // a start only sees registered state, so PENDING always lasts at least one cycle
            if (r_consumer == 1'(i) && !w_run_any) begin
               w_nxt[i]   = RUNNING;
               w_start[i] = 1'b1;
            end
         end else if (op_done) begin
            w_nxt[i]  = w_wr ? PENDING : IDLE;
            w_done[i] = 1'b1;
         end else begin
            w_err = w_err | w_wr;
         end
      end
   end

   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         r_st[0]    <= IDLE;
         r_st[1]    <= IDLE;
         r_consumer <= 1'b0;
         r_op_start <= 1'b0;
         r_done     <= 2'b00;
         r_err      <= 1'b0;
      end else begin
         r_st[0]    <= w_nxt[0];
         r_st[1]    <= w_nxt[1];
         r_consumer <= r_consumer ^ (|w_done);
         r_op_start <= |w_start;
         r_done     <= w_done;
         r_err      <= w_err;
      end
   end

   assign consumer  = r_consumer;
   assign status_0  = r_st[0];
   assign status_1  = r_st[1];
   assign op_en_0   = r_st[0] != IDLE;
   assign op_en_1   = r_st[1] != IDLE;
   assign op_start  = r_op_start;
   assign done_intr = r_done;
   assign err_pulse = r_err;

`ifdef NVDLA_PDP_GROUP_PERF_EN
   logic [PERF_CNT_W-1:0] r_perf [2];

   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         r_perf[0] <= '0;
         r_perf[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (r_st[i] == IDLE && w_nxt[i] == PENDING)
               r_perf[i] <= '0;
            else if (r_st[i] == RUNNING && !(&r_perf[i]))
               r_perf[i] <= r_perf[i] + PERF_CNT_W'(1);
         end
      end
   end

   assign perf_busy_0 = r_perf[0];
   assign perf_busy_1 = r_perf[1];
`endif
endmodule

// File: tb/tb_nv_nvdla_pdp_group_tracker.sv
// tb_nv_nvdla_pdp_group_tracker: directed self-checking bench for the PDP group tracker.
module tb_nv_nvdla_pdp_group_tracker;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       producer = 1'b0, op_en_wr = 1'b0, op_done = 1'b0;
   logic       consumer, op_en_0, op_en_1, op_start, err_pulse;
   logic [1:0] status_0, status_1, done_intr;
`ifdef NVDLA_PDP_GROUP_PERF_EN
   logic [31:0] perf_busy_0, perf_busy_1;
`endif
   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   nv_nvdla_pdp_group_tracker #(.PERF_CNT_W(32)) dut (
      .nvdla_core_clk(clk),
      .nvdla_core_rst(rst),
      .producer(producer),
      .op_en_wr(op_en_wr),
      .op_done(op_done),
      .consumer(consumer),
      .status_0(status_0),
      .status_1(status_1),
      .op_en_0(op_en_0),
      .op_en_1(op_en_1),
      .op_start(op_start),
      .done_intr(done_intr),
      .err_pulse(err_pulse)
`ifdef NVDLA_PDP_GROUP_PERF_EN
      ,
      .perf_busy_0(perf_busy_0),
      .perf_busy_1(perf_busy_1)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // drive one cycle of strobes, then clear them
   task automatic ev(input logic p, input logic w, input logic d);
      producer = p;
      op_en_wr = w;
      op_done  = d;
      tick();
      op_en_wr = 1'b0;
      op_done  = 1'b0;
   endtask

   task automatic chk_st(input string tag, input logic [1:0] s0, input logic [1:0] s1, input logic c);
      chk({tag, "_s0"}, status_0, s0);
      chk({tag, "_s1"}, status_1, s1);
      chk({tag, "_cons"}, consumer, c);
   endtask

   task automatic chk_pulse(input string tag, input logic st, input logic [1:0] di, input logic er);
      chk({tag, "_start"}, op_start, st);
      chk({tag, "_done"}, done_intr, di);
      chk({tag, "_err"}, err_pulse, er);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      tick();
      tick();
      chk_st("rst", 2'd0, 2'd0, 1'b0);
      chk_pulse("rst", 1'b0, 2'b00, 1'b0);
      chk("rst_en0", op_en_0, 1'b0);
      chk("rst_en1", op_en_1, 1'b0);
      rst = 1'b0;

      // single layer on group 0
      ev(1'b0, 1'b1, 1'b0);
      chk_st("g0_pend", 2'd2, 2'd0, 1'b0);
      chk("g0_pend_en", op_en_0, 1'b1);
      chk("g0_pend_start", op_start, 1'b0);
      tick();
      chk_st("g0_run", 2'd1, 2'd0, 1'b0);
      chk_pulse("g0_run", 1'b1, 2'b00, 1'b0);
      chk("g0_run_en", op_en_0, 1'b1);
      tick();
      chk("g0_run2_start", op_start, 1'b0);
      chk("g0_run2_s0", status_0, 2'd1);
      ev(1'b0, 1'b0, 1'b1);
      chk_st("g0_done", 2'd0, 2'd0, 1'b1);
      chk_pulse("g0_done", 1'b0, 2'b01, 1'b0);
      chk("g0_done_en", op_en_0, 1'b0);
      tick();
      chk("g0_done2_di", done_intr, 2'b00);

      // ping-pong
      do_reset();
      ev(1'b0, 1'b1, 1'b0);
      tick();
      chk_st("pp_g0run", 2'd1, 2'd0, 1'b0);
      ev(1'b1, 1'b1, 1'b0);
      chk_st("pp_g1pend", 2'd1, 2'd2, 1'b0);
      chk("pp_g1pend_en", op_en_1, 1'b1);
      tick();
      chk_st("pp_g1hold", 2'd1, 2'd2, 1'b0);
      ev(1'b0, 1'b0, 1'b1);
      chk_st("pp_done0", 2'd0, 2'd2, 1'b1);
      chk_pulse("pp_done0", 1'b0, 2'b01, 1'b0);
      tick();
      chk_st("pp_g1run", 2'd0, 2'd1, 1'b1);
      chk_pulse("pp_g1run", 1'b1, 2'b00, 1'b0);
      ev(1'b0, 1'b0, 1'b1);
      chk_st("pp_done1", 2'd0, 2'd0, 1'b0);
      chk_pulse("pp_done1", 1'b0, 2'b10, 1'b0);

      // illegal events
      ev(1'b0, 1'b0, 1'b1);
      chk_st("ill_done", 2'd0, 2'd0, 1'b0);
      chk_pulse("ill_done", 1'b0, 2'b00, 1'b1);
      tick();
      chk("ill_done_clr", err_pulse, 1'b0);
      ev(1'b1, 1'b1, 1'b0);
      tick();
      chk_st("ill_g1wait", 2'd0, 2'd2, 1'b0);
      ev(1'b1, 1'b1, 1'b0);
      chk_st("ill_pendwr", 2'd0, 2'd2, 1'b0);
      chk("ill_pendwr_err", err_pulse, 1'b1);
      ev(1'b0, 1'b1, 1'b0);
      tick();
      chk_st("ill_g0run", 2'd1, 2'd2, 1'b0);
      ev(1'b0, 1'b1, 1'b0);
      chk_st("ill_runwr", 2'd1, 2'd2, 1'b0);
      chk("ill_runwr_err", err_pulse, 1'b1);

      // simultaneous op_en_wr and op_done on the running group
      ev(1'b0, 1'b1, 1'b1);
      chk_st("sim", 2'd2, 2'd2, 1'b1);
      chk_pulse("sim", 1'b0, 2'b01, 1'b0);
      tick();
      chk_st("sim_g1run", 2'd2, 2'd1, 1'b1);
      chk("sim_g1run_start", op_start, 1'b1);
      for (int i = 0; i < 5; i++) tick();
      chk_st("sim_hold", 2'd2, 2'd1, 1'b1);
`ifdef NVDLA_PDP_GROUP_PERF_EN
      chk("perf1_5", perf_busy_1, 32'd5);
      chk("perf0_0", perf_busy_0, 32'd0);
`endif

      // asynchronous reset mid-layer
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk_st("arst", 2'd0, 2'd0, 1'b0);
      chk_pulse("arst", 1'b0, 2'b00, 1'b0);
      chk("arst_en0", op_en_0, 1'b0);
      chk("arst_en1", op_en_1, 1'b0);
`ifdef NVDLA_PDP_GROUP_PERF_EN
      chk("arst_perf1", perf_busy_1, 32'd0);
`endif
      tick();
      rst = 1'b0;

      // different-group op_en_wr and op_done in the same cycle
      ev(1'b1, 1'b1, 1'b0);
      chk_st("xg_g1pend", 2'd0, 2'd2, 1'b0);
      ev(1'b0, 1'b1, 1'b0);
      tick();
      chk_st("xg_g0run", 2'd1, 2'd2, 1'b0);
      ev(1'b1, 1'b0, 1'b1);
      ev(1'b1, 1'b0, 1'b0);
      chk_st("xg_g1run", 2'd0, 2'd1, 1'b1);
      ev(1'b0, 1'b1, 1'b1);
      chk_st("xg_both", 2'd2, 2'd0, 1'b0);
      chk_pulse("xg_both", 1'b0, 2'b10, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
